// File: rtl/exposure_sequencer.sv
// Capture sequencer for a CCD timing generator: shutter flush, timed exposure
// with optional flash, readout, and burst repetition with handshake watchdogs.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// S_IDLE    | waiting for start; configuration is sampled on acceptance
// S_FLUSH   | electronic-shutter flush requested, waiting for eshut_done
// S_EXPOSE  | integrating for max(exp_lines,1) line ticks, flash enabled
// S_READOUT | frame transfer requested, waiting for frame_done
// S_NEXT    | one cycle: decide between another frame and sequence end
// S_ABORT   | sequence cancelled, waiting for the timing generator to idle
// S_ERROR   | handshake timed out, waiting for the timing generator to idle
module exposure_sequencer (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        abort,
    input  logic        cfg_mode,
    input  logic [7:0]  cfg_frames,
    input  logic [15:0] cfg_exp_lines,
    input  logic [15:0] cfg_line_clks,
    input  logic        cfg_flash_en,
    input  logic [15:0] cfg_timeout,
    output logic        eshut_req,
    input  logic        eshut_done,
    output logic        rd_req,
    input  logic        frame_done,
    input  logic        tgen_busy,
    output logic        tgen_en,
    output logic        flash_out,
    output logic        busy,
    output logic [7:0]  frame_cnt,
    output logic        seq_done,
    output logic        err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FLUSH,
        S_EXPOSE,
        S_READOUT,
        S_NEXT,
        S_ABORT,
        S_ERROR
    } state_t;

    state_t      state;

    logic        mode_q;
    logic [7:0]  frames_q;
    logic [15:0] exp_lines_q;
    logic [15:0] line_clks_q;
    logic        flash_en_q;
    logic [15:0] timeout_q;

    logic [15:0] presc_cnt;
    logic [15:0] exp_cnt;
    logic [15:0] wd_cnt;

    logic        wd_expired;
    logic        line_tick;
    logic        exp_last;

    // exp_lines_q is stored already clamped to at least 1, so the subtraction cannot wrap
    assign wd_expired = (timeout_q != 16'd0) && (wd_cnt == timeout_q - 16'd1);
    assign line_tick  = (presc_cnt == line_clks_q);
    assign exp_last   = (exp_cnt == exp_lines_q - 16'd1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            mode_q      <= 1'b0;
            frames_q    <= 8'd0;
            exp_lines_q <= 16'd0;
            line_clks_q <= 16'd0;
            flash_en_q  <= 1'b0;
            timeout_q   <= 16'd0;
            presc_cnt   <= 16'd0;
            exp_cnt     <= 16'd0;
            wd_cnt      <= 16'd0;
            eshut_req   <= 1'b0;
            rd_req      <= 1'b0;
            tgen_en     <= 1'b0;
            flash_out   <= 1'b0;
            busy        <= 1'b0;
            frame_cnt   <= 8'd0;
            seq_done    <= 1'b0;
            err         <= 1'b0;
        end else begin
            eshut_req <= 1'b0;
            rd_req    <= 1'b0;
            seq_done  <= 1'b0;

            // abort outranks every acknowledge and timeout in the same cycle
            if (abort && state != S_IDLE && state != S_ABORT) begin
                state     <= S_ABORT;
                tgen_en   <= 1'b0;
                flash_out <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (start && !abort) begin
                            mode_q      <= cfg_mode;
                            frames_q    <= cfg_frames;
                            exp_lines_q <= (cfg_exp_lines == 16'd0) ? 16'd1 : cfg_exp_lines;
                            line_clks_q <= cfg_line_clks;
                            flash_en_q  <= cfg_flash_en;
                            timeout_q   <= cfg_timeout;
                            frame_cnt   <= 8'd0;
                            err         <= 1'b0;
                            wd_cnt      <= 16'd0;
                            eshut_req   <= 1'b1;
                            tgen_en     <= 1'b1;
                            busy        <= 1'b1;
                            state       <= S_FLUSH;
                        end
                    end
                    S_FLUSH: begin
                        if (eshut_done) begin
                            presc_cnt <= 16'd0;
                            exp_cnt   <= 16'd0;
                            flash_out <= flash_en_q;
                            state     <= S_EXPOSE;
                        end else if (wd_expired) begin
                            err     <= 1'b1;
                            tgen_en <= 1'b0;
                            state   <= S_ERROR;
                        end else begin
                            wd_cnt <= wd_cnt + 16'd1;
                        end
                    end
                    S_EXPOSE: begin
                        if (line_tick) begin
                            presc_cnt <= 16'd0;
                            if (exp_last) begin
                                flash_out <= 1'b0;
                                rd_req    <= 1'b1;
                                wd_cnt    <= 16'd0;
                                state     <= S_READOUT;
                            end else begin
                                exp_cnt <= exp_cnt + 16'd1;
                            end
                        end else begin
                            presc_cnt <= presc_cnt + 16'd1;
                        end
                    end
                    S_READOUT: begin
                        if (frame_done) begin
                            if (frame_cnt != 8'hFF) begin
                                frame_cnt <= frame_cnt + 8'd1;
                            end
                            state <= S_NEXT;
                        end else if (wd_expired) begin
                            err     <= 1'b1;
                            tgen_en <= 1'b0;
                            state   <= S_ERROR;
                        end else begin
                            wd_cnt <= wd_cnt + 16'd1;
                        end
                    end
                    S_NEXT: begin
                        if (!mode_q || (frames_q != 8'd0 && frame_cnt == frames_q)) begin
                            seq_done <= 1'b1;
                            tgen_en  <= 1'b0;
                            busy     <= 1'b0;
                            state    <= S_IDLE;
                        end else begin
                            eshut_req <= 1'b1;
                            wd_cnt    <= 16'd0;
                            state     <= S_FLUSH;
                        end
                    end
                    S_ABORT, S_ERROR: begin
                        if (!tgen_busy) begin
                            busy  <= 1'b0;
                            state <= S_IDLE;
                        end
                    end
                    default: begin
                        tgen_en   <= 1'b0;
                        flash_out <= 1'b0;
                        busy      <= 1'b0;
                        state     <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_exposure_sequencer.sv
// Bench for exposure_sequencer: a responder answers shutter and readout
// requests with random delays while expected timing comes from frame arithmetic.
module tb_exposure_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        abort;
    logic        cfg_mode;
    logic [7:0]  cfg_frames;
    logic [15:0] cfg_exp_lines;
    logic [15:0] cfg_line_clks;
    logic        cfg_flash_en;
    logic [15:0] cfg_timeout;
    logic        eshut_req;
    logic        eshut_done;
    logic        rd_req;
    logic        frame_done;
    logic        tgen_busy;
    logic        tgen_en;
    logic        flash_out;
    logic        busy;
    logic [7:0]  frame_cnt;
    logic        seq_done;
    logic        err;

    int tests_run = 0;
    int fails     = 0;

    exposure_sequencer dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .abort        (abort),
        .cfg_mode     (cfg_mode),
        .cfg_frames   (cfg_frames),
        .cfg_exp_lines(cfg_exp_lines),
        .cfg_line_clks(cfg_line_clks),
        .cfg_flash_en (cfg_flash_en),
        .cfg_timeout  (cfg_timeout),
        .eshut_req    (eshut_req),
        .eshut_done   (eshut_done),
        .rd_req       (rd_req),
        .frame_done   (frame_done),
        .tgen_busy    (tgen_busy),
        .tgen_en      (tgen_en),
        .flash_out    (flash_out),
        .busy         (busy),
        .frame_cnt    (frame_cnt),
        .seq_done     (seq_done),
        .err          (err)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation still running at %0t", $time);
        $fatal(1, "bench time limit exceeded");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cfg(input logic mode, input logic [7:0] frames, input logic [15:0] exp_l,
                           input logic [15:0] lc, input logic fl, input logic [15:0] tmo);
        cfg_mode      = mode;
        cfg_frames    = frames;
        cfg_exp_lines = exp_l;
        cfg_line_clks = lc;
        cfg_flash_en  = fl;
        cfg_timeout   = tmo;
    endtask

    task automatic scramble_cfg();
        cfg_mode      = 1'($urandom_range(1, 0));
        cfg_frames    = 8'($urandom_range(255, 0));
        cfg_exp_lines = 16'($urandom_range(65535, 0));
        cfg_line_clks = 16'($urandom_range(65535, 0));
        cfg_flash_en  = 1'($urandom_range(1, 0));
        cfg_timeout   = 16'($urandom_range(3, 0));
    endtask

    // One full sequence against a responder. Expected values come from the frame
    // count N and exposure length L = max(exp,1)*(lc+1); abort_at>0 aborts on that
    // flush request instead of answering it.
    task automatic run_sequence(input string tag, input logic mode, input logic [7:0] frames,
                                input logic [15:0] exp_l, input logic [15:0] lc, input logic fl,
                                input logic [15:0] tmo, input int de, input int df,
                                input int abort_at, input logic scramble);
        int L, n_exp_esh, n_exp_rd, n_exp_fc, exp_idle;
        int e_timer = 0, f_timer = 0;
        int n_esh = 0, n_rd = 0, n_sd = 0;
        int flash_run = 0, flash_total = 0;
        int done_cyc = -1, fd_cyc = -1, sd_cyc = -1, idle_cyc = -1, abort_cyc = -1;
        int tg_bad = 0;
        logic stray_e_ok = 1'b0, stray_f_ok = 1'b0, abort_now = 1'b0;

        L = ((exp_l == 16'd0) ? 1 : int'(exp_l)) * (int'(lc) + 1);
        if (abort_at != 0) begin
            n_exp_esh = abort_at;
            n_exp_rd  = abort_at - 1;
        end else begin
            n_exp_esh = mode ? int'(frames) : 1;
            n_exp_rd  = n_exp_esh;
        end
        n_exp_fc = (n_exp_rd > 255) ? 255 : n_exp_rd;

        set_cfg(mode, frames, exp_l, lc, fl, tmo);
        tgen_busy = 1'b1;
        start     = 1'b1;
        step();
        start = 1'b0;

        for (int cyc = 0; cyc < 4000; cyc++) begin
            eshut_done = 1'b0;
            frame_done = 1'b0;
            abort      = 1'b0;
            start      = 1'b0;
            if (abort_cyc >= 0) tgen_busy = 1'b0;
            if (e_timer > 0) begin
                e_timer--;
                if (e_timer == 0) begin
                    eshut_done = 1'b1;
                    done_cyc   = cyc;
                    stray_e_ok = 1'b1;
                end
            end
            if (f_timer > 0) begin
                f_timer--;
                if (f_timer == 0) begin
                    frame_done = 1'b1;
                    fd_cyc     = cyc;
                end
            end

            flash_run   += int'(flash_out);
            flash_total += int'(flash_out);
            if (eshut_req) begin
                n_esh++;
                stray_e_ok = 1'b0;
                stray_f_ok = 1'b1;
                if (abort_at != 0 && n_esh == abort_at) abort_now = 1'b1;
                else e_timer = de;
            end
            if (rd_req) begin
                n_rd++;
                stray_f_ok = 1'b0;
                f_timer    = df;
                tests_run++;
                if (cyc - done_cyc !== L + 1) begin
                    fails++;
                    $display("FAIL %s expose_len frame %0d: got %0d expected %0d", tag, n_rd, cyc - done_cyc - 1, L);
                end
                tests_run++;
                if (flash_run !== (fl ? L : 0)) begin
                    fails++;
                    $display("FAIL %s flash_len frame %0d: got %0d expected %0d", tag, n_rd, flash_run, fl ? L : 0);
                end
                flash_run = 0;
            end
            if (seq_done) begin
                n_sd++;
                sd_cyc = cyc;
            end
            if (fd_cyc >= 0 && cyc == fd_cyc + 1) begin
                tests_run++;
                if (int'(frame_cnt) !== ((n_rd > 255) ? 255 : n_rd)) begin
                    fails++;
                    $display("FAIL %s frame_cnt_step: got %0d expected %0d", tag, frame_cnt, (n_rd > 255) ? 255 : n_rd);
                end
            end
            if (abort_cyc < 0 && tgen_en !== busy) tg_bad++;
            if (!busy) begin
                idle_cyc = cyc;
                break;
            end

            if (abort_now) begin
                abort     = 1'b1;
                abort_cyc = cyc;
                abort_now = 1'b0;
            end
            if (stray_e_ok && !eshut_done && $urandom_range(7, 0) == 0) eshut_done = 1'b1;
            if (stray_f_ok && !frame_done && $urandom_range(7, 0) == 0) frame_done = 1'b1;
            if (scramble) begin
                scramble_cfg();
                start = ($urandom_range(3, 0) == 0);
            end
            step();
        end

        eshut_done = 1'b0;
        frame_done = 1'b0;
        abort      = 1'b0;
        start      = 1'b0;
        tgen_busy  = 1'b0;

        exp_idle = (abort_at != 0) ? abort_cyc + 2 : fd_cyc + 2;
        tests_run++;
        if (idle_cyc !== exp_idle) begin
            fails++;
            $display("FAIL %s idle_cycle: got %0d expected %0d", tag, idle_cyc, exp_idle);
        end
        tests_run++;
        if (n_esh !== n_exp_esh) begin
            fails++;
            $display("FAIL %s eshut_req_count: got %0d expected %0d", tag, n_esh, n_exp_esh);
        end
        tests_run++;
        if (n_rd !== n_exp_rd) begin
            fails++;
            $display("FAIL %s rd_req_count: got %0d expected %0d", tag, n_rd, n_exp_rd);
        end
        tests_run++;
        if (n_sd !== ((abort_at != 0) ? 0 : 1)) begin
            fails++;
            $display("FAIL %s seq_done_count: got %0d expected %0d", tag, n_sd, (abort_at != 0) ? 0 : 1);
        end
        if (abort_at == 0) begin
            tests_run++;
            if (sd_cyc !== exp_idle) begin
                fails++;
                $display("FAIL %s seq_done_cycle: got %0d expected %0d", tag, sd_cyc, exp_idle);
            end
        end
        tests_run++;
        if (int'(frame_cnt) !== n_exp_fc) begin
            fails++;
            $display("FAIL %s frame_cnt_final: got %0d expected %0d", tag, frame_cnt, n_exp_fc);
        end
        tests_run++;
        if (tg_bad !== 0) begin
            fails++;
            $display("FAIL %s tgen_en_vs_busy: got %0d bad cycles expected 0", tag, tg_bad);
        end
        tests_run++;
        if (flash_total !== n_rd * L * (fl ? 1 : 0)) begin
            fails++;
            $display("FAIL %s flash_total: got %0d expected %0d", tag, flash_total, n_rd * L * (fl ? 1 : 0));
        end
        tests_run++;
        if (err !== 1'b0) begin
            fails++;
            $display("FAIL %s err_after_run: got %b expected 0", tag, err);
        end
    endtask

    task automatic test_reset();
        logic [14:0] outs;
        rst = 1'b1;
        scramble_cfg();
        start = 1'b1;
        step();
        step();
        outs = {eshut_req, rd_req, tgen_en, flash_out, busy, seq_done, err, frame_cnt};
        tests_run++;
        if (outs !== 15'd0) begin
            fails++;
            $display("FAIL reset_outputs: got %h expected 0000", outs);
        end
        start = 1'b0;
        rst   = 1'b0;
        step();
        tests_run++;
        if (busy !== 1'b0) begin
            fails++;
            $display("FAIL reset_release_idle: got busy=%b expected 0", busy);
        end
    endtask

    task automatic test_single();
        run_sequence("single", 1'b0, 8'd0, 16'd3, 16'd9, 1'b1, 16'd0, 5, 7, 0, 1'b0);
    endtask

    task automatic test_burst();
        run_sequence("burst", 1'b1, 8'd3, 16'd2, 16'd4, 1'b1, 16'd50, 3, 6, 0, 1'b1);
    endtask

    task automatic test_zero_exposure();
        run_sequence("zero_exp", 1'b0, 8'd0, 16'd0, 16'd0, 1'b1, 16'd0, 2, 2, 0, 1'b0);
    endtask

    task automatic test_random();
        for (int it = 0; it < 6; it++) begin
            run_sequence($sformatf("rand%0d", it), 1'($urandom_range(1, 0)), 8'($urandom_range(4, 1)),
                         16'($urandom_range(6, 0)), 16'($urandom_range(5, 0)), 1'($urandom_range(1, 0)),
                         ($urandom_range(1, 0) == 0) ? 16'd0 : 16'($urandom_range(40, 9)),
                         int'($urandom_range(8, 1)), int'($urandom_range(8, 1)), 0, 1'b1);
        end
    endtask

    task automatic test_abort_expose();
        for (int it = 0; it < 3; it++) begin
            int h, j, k0, bad;
            h   = (it == 0) ? 4 : int'($urandom_range(5, 0));
            j   = (it == 0) ? 3 : int'($urandom_range(19, 1));
            k0  = (h < 1) ? 1 : h;
            bad = 0;
            set_cfg(1'b0, 8'd0, 16'd5, 16'd3, 1'b1, 16'd0);
            tgen_busy = 1'b1;
            start     = 1'b1;
            step();
            start      = 1'b0;
            eshut_done = 1'b1;
            step();
            eshut_done = 1'b0;
            for (int k = 1; k < j; k++) step();
            tests_run++;
            if (flash_out !== 1'b1) begin
                fails++;
                $display("FAIL abort%0d flash_before_abort: got %b expected 1", it, flash_out);
            end
            abort = 1'b1;
            step();
            abort = 1'b0;
            tests_run++;
            if ({flash_out, tgen_en, busy} !== 3'b001) begin
                fails++;
                $display("FAIL abort%0d abort_entry: got flash/tgen_en/busy=%b expected 001", it, {flash_out, tgen_en, busy});
            end
            for (int k = 1; k <= 7; k++) begin
                if (busy !== (k <= k0)) bad++;
                if (rd_req || seq_done || eshut_req || flash_out) bad++;
                tgen_busy = (k < h);
                step();
            end
            tgen_busy = 1'b0;
            tests_run++;
            if (bad !== 0) begin
                fails++;
                $display("FAIL abort%0d abort_exit (hold %0d): got %0d bad cycles expected 0", it, h, bad);
            end
        end
    endtask

    task automatic test_timeout();
        int err_early = 0;
        set_cfg(1'b0, 8'd1, 16'd2, 16'd1, 1'b0, 16'd20);
        tgen_busy = 1'b1;
        start     = 1'b1;
        step();
        start = 1'b0;
        for (int k = 1; k <= 19; k++) begin
            step();
            if (err) err_early++;
        end
        tests_run++;
        if (err_early !== 0) begin
            fails++;
            $display("FAIL timeout_early: got %0d cycles with err expected 0", err_early);
        end
        step();
        tests_run++;
        if ({err, tgen_en, busy} !== 3'b101) begin
            fails++;
            $display("FAIL timeout_fire: got err/tgen_en/busy=%b expected 101", {err, tgen_en, busy});
        end
        tgen_busy = 1'b0;
        step();
        tests_run++;
        if ({err, busy} !== 2'b10) begin
            fails++;
            $display("FAIL timeout_error_exit: got err/busy=%b expected 10", {err, busy});
        end
        // acknowledges land on the very cycle the watchdog would fire
        run_sequence("after_timeout", 1'b0, 8'd1, 16'd2, 16'd1, 1'b1, 16'd20, 19, 19, 0, 1'b0);
    endtask

    task automatic test_corners();
        start = 1'b1;
        abort = 1'b1;
        step();
        start = 1'b0;
        abort = 1'b0;
        tests_run++;
        if ({busy, eshut_req, tgen_en} !== 3'b000) begin
            fails++;
            $display("FAIL start_abort_idle: got busy/eshut_req/tgen_en=%b expected 000", {busy, eshut_req, tgen_en});
        end

        set_cfg(1'b0, 8'd0, 16'd0, 16'd0, 1'b1, 16'd0);
        tgen_busy  = 1'b1;
        start      = 1'b1;
        step();
        start      = 1'b0;
        eshut_done = 1'b1;
        step();
        eshut_done = 1'b0;
        step();
        tests_run++;
        if ({flash_out, rd_req} !== 2'b01) begin
            fails++;
            $display("FAIL readout_entry: got flash/rd_req=%b expected 01", {flash_out, rd_req});
        end
        rst = 1'b1;
        step();
        tests_run++;
        if ({eshut_req, rd_req, tgen_en, flash_out, busy, seq_done, err, frame_cnt} !== 15'd0) begin
            fails++;
            $display("FAIL rst_in_readout: got %h expected 0000",
                     {eshut_req, rd_req, tgen_en, flash_out, busy, seq_done, err, frame_cnt});
        end
        rst       = 1'b0;
        tgen_busy = 1'b0;
        step();

        set_cfg(1'b1, 8'd2, 16'd0, 16'd0, 1'b0, 16'd0);
        tgen_busy  = 1'b1;
        start      = 1'b1;
        step();
        start      = 1'b0;
        eshut_done = 1'b1;
        step();
        eshut_done = 1'b0;
        step();
        frame_done = 1'b1;
        abort      = 1'b1;
        tgen_busy  = 1'b0;
        step();
        frame_done = 1'b0;
        abort      = 1'b0;
        tests_run++;
        if ({frame_cnt, seq_done, busy, tgen_en} !== {8'd0, 1'b0, 1'b1, 1'b0}) begin
            fails++;
            $display("FAIL abort_beats_frame_done: got cnt=%0d sd=%b busy=%b en=%b expected cnt=0 sd=0 busy=1 en=0",
                     frame_cnt, seq_done, busy, tgen_en);
        end
        step();
        tests_run++;
        if ({busy, seq_done} !== 2'b00) begin
            fails++;
            $display("FAIL abort_idle: got busy/seq_done=%b expected 00", {busy, seq_done});
        end
        eshut_done = 1'b1;
        frame_done = 1'b1;
        step();
        eshut_done = 1'b0;
        frame_done = 1'b0;
        step();
        tests_run++;
        if ({busy, eshut_req, rd_req, frame_cnt} !== 11'd0) begin
            fails++;
            $display("FAIL stray_ack_idle: got %h expected 000", {busy, eshut_req, rd_req, frame_cnt});
        end
    endtask

    task automatic test_saturation();
        run_sequence("unlimited_sat", 1'b1, 8'd0, 16'd0, 16'd0, 1'b0, 16'd0, 1, 1, 258, 1'b1);
    endtask

    initial begin
        rst        = 1'b1;
        start      = 1'b0;
        abort      = 1'b0;
        eshut_done = 1'b0;
        frame_done = 1'b0;
        tgen_busy  = 1'b0;
        set_cfg(1'b0, 8'd0, 16'd0, 16'd0, 1'b0, 16'd0);

        test_reset();
        test_single();
        test_burst();
        test_zero_exposure();
        test_random();
        test_abort_expose();
        test_timeout();
        test_corners();
        test_saturation();

        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
